ldtu_gain_sel_fifo: RTL
=======================

Name: ldtu_gain_sel_fifo

Overview:
- Parametrised, single-clock successor of the LiTe-DTU input FIFO and gain-selection stage.
- Buffers baseline-subtracted gain x1 and gain x10 samples in twin ring buffers.
- Looks ahead a programmable number of samples for gain-x10 saturation and holds gain x1 for a programmable window.
- Emits one 13-bit tagged sample per accepted input, with baseline flag, gain-switch pulse and saturation statistics, toward the encoder.

Parameters:
NBITS, 12, sample width per gain
DEPTH, 16, ring depth per gain (power of 2, >=4)
PTR_W, 4, log2(DEPTH)
WIN_W, 6, width of window_len (max window 2^WIN_W-1)
BASE_BITS, 6, low bits ignored by baseline test
CNT_W, 16, saturation event counter width

Ports:
CLK_  in  1  LiTe-DTU clock
reset_  in  1  synchronous, active-low reset (1'b0 = reset)
in_valid  in  1  sample strobe; both gains written when high
DATA_gain_01  in  NBITS  gain x1 sample
DATA_gain_10  in  NBITS  gain x10 sample
GAIN_SEL_MODE  in  2  00 auto/window, 01 auto/2xwindow, 10 force x10, 11 force x1
window_len  in  WIN_W  hold window in samples (0 treated as 1)
lookahead  in  PTR_W  reference distance L, 0..DEPTH-1
SATURATION_value  in  NBITS  saturation threshold before shift
shift_gain_10  in  2  right shift applied to gain x10 data and threshold
clr_cnt  in  1  clears sat_count
DATA_to_enc  out  NBITS+1  {gain bit (1 = x1), sample}
out_valid  out  1  DATA_to_enc valid
baseline_flag  out  1  sample is baseline
gain_switch  out  1  one-cycle pulse on gain-bit change between consecutive valid outputs
sat_count  out  CNT_W  number of saturated reference samples, saturating

Behaviour:
- Reset (reset_=0 at CLK_ edge): pointers, fill, hold_cnt, sat_count = 0; rings = 0; SATval = all ones; DATA_to_enc = 0; out_valid = 0; gain_switch = 0; baseline_flag = 1.
- SATval is registered every cycle as SATURATION_value >> shift_gain_10. The x10 ring stores DATA_gain_10 >> shift_gain_10.
- Write: on in_valid, both rings write at wr_ptr; wr_ptr increments mod DEPTH; fill increments and saturates at L+1.
- Reference: the incoming x10 sample (after shift).
  - ref_sat = (shifted sample >= SATval) in auto modes; 0 in mode 10; 1 in mode 11.
- Read: when in_valid and fill == L+1 (fill value counts the current write), sample at wr_ptr - L mod DEPTH is registered to the output and out_valid = 1 on the next cycle. Otherwise out_valid = 0.
  - Latency: sample k appears one cycle after the in_valid of sample k+L.
  - L=0 gives 1-cycle pass-through.
- Hold: W = window_len, or 2*window_len in mode 01 (computed WIN_W+1 wide); W=0 is treated as 1.
  - On in_valid, if ref_sat, hold_cnt <= W-1 and the emitted sample uses x1.
  - Else if hold_cnt != 0, hold_cnt decrements and the emitted sample uses x1.
  - Else the emitted sample uses x10.
  - Net effect: one saturated reference forces exactly W consecutive outputs to x1, starting L samples before the saturated sample.
  - Retriggering reloads hold_cnt (no accumulation).
  - Mode 10 forces x10; mode 11 forces x1; hold_cnt is cleared while in modes 10/11.
- Emitted data: {1'b0, x10} or {1'b1, x1}.
- baseline_flag (registered with output):
  - Modes 00/01: DATA_to_enc[NBITS:BASE_BITS] == 0.
  - Modes 10/11: DATA_to_enc[NBITS-1:BASE_BITS] == 0.
  - Holds its value when out_valid = 0.
- gain_switch: 1 for one cycle with a valid output whose gain bit differs from the previous valid output. The first output after reset or flush never pulses.
- sat_count: +1 per in_valid with ref_sat in auto modes only; saturates at all ones. clr_cnt has priority: on simultaneous clr_cnt and event, the count becomes 1.
- lookahead change: lookahead is registered internally; any change causes a flush.
  - Flush: fill = 0, hold_cnt = 0, out_valid = 0.
  - Output resumes after L+1 new samples; no stale samples are emitted.
- in_valid gaps: all state is frozen; DATA_to_enc is held.

Decomposition:
- ldtu_pkg:
  - GAIN_SEL_MODE encodings (AUTO, AUTO2X, FORCE_G10, FORCE_G1)
  - default widths
  - gain-bit constant
- Sub-module ldtu_dual_ring: twin DEPTH x NBITS rings with shared write pointer and one read address. It is instantiated once; the hold/selection logic stays in the top.

Test Plan:
1. Reset with in_valid toggling -> out_valid=0, baseline_flag=1, DATA_to_enc=0, sat_count=0; first output appears 1 cycle after the (L+1)th sample.
2. Mode 00, L=3, window_len=8, SATURATION_value=0xFFF, shift 0; x10 ramp with sample 10 = 0xFFF -> outputs 7..14 carry {1,g1}, all others {0,g10}; gain_switch at outputs 7 and 15; sat_count=1.
3. Mode 01, same stimulus -> outputs 7..22 are x1. Mode 10 -> all {0,g10} and sat_count unchanged.
4. Mode 11, g1=0x03F then 0x040 -> DATA_to_enc=0x103F with baseline_flag=1, then 0x1040 with baseline_flag=0.
5. Random in_valid gaps (30% duty) with a 200-sample reference model -> output order and gain tags match; out_valid only one cycle after in_valid.
6. Change lookahead 3->5 mid-stream -> out_valid low for the next 5 samples, resumes on the 6th; no duplicate or stale samples. Simultaneous clr_cnt and saturation -> sat_count=1.

Source files
------------

// File: rtl/ldtu_pkg.sv
// ----------------------------------------------------------------------------
// ldtu_pkg
// Shared definitions for the LiTe-DTU gain-selection FIFO slice: default
// widths, GAIN_SEL_MODE encodings and the gain-bit values placed in bit NBITS
// of the word sent to the encoder.
// ----------------------------------------------------------------------------
package ldtu_pkg;

    localparam int NBITS_DEF     = 12;
    localparam int DEPTH_DEF     = 16;
    localparam int PTR_W_DEF     = 4;
    localparam int WIN_W_DEF     = 6;
    localparam int BASE_BITS_DEF = 6;
    localparam int CNT_W_DEF     = 16;

    typedef enum logic [1:0] {
        MODE_AUTO      = 2'b00,
        MODE_AUTO2X    = 2'b01,
        MODE_FORCE_G10 = 2'b10,
        MODE_FORCE_G1  = 2'b11
    } gain_mode_e;

    localparam logic GAIN_X1  = 1'b1;
    localparam logic GAIN_X10 = 1'b0;

    function automatic logic is_auto_mode(input gain_mode_e m);
        return (m == MODE_AUTO) || (m == MODE_AUTO2X);
    endfunction

endpackage

// File: rtl/ldtu_dual_ring.sv
// ----------------------------------------------------------------------------
// ldtu_dual_ring
// Twin DEPTH x NBITS ring buffers (gain x1 and gain x10) sharing one write
// pointer and one read address.
//
// Ports:
//   CLK_     in   clock
//   reset_   in   synchronous active-low reset, clears both rings
//   we       in   write both rings at wr_ptr
//   wr_ptr   in   shared write address
//   wr_g01   in   gain x1 write data
//   wr_g10   in   gain x10 write data (already shifted)
//   rd_ptr   in   shared read address
//   rd_g01   out  gain x1 read data
//   rd_g10   out  gain x10 read data
// ----------------------------------------------------------------------------
module ldtu_dual_ring
    import ldtu_pkg::*;
#(
    parameter int NBITS = NBITS_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int PTR_W = PTR_W_DEF
) (
    input  logic             CLK_,
    input  logic             reset_,
    input  logic             we,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [NBITS-1:0] wr_g01,
    input  logic [NBITS-1:0] wr_g10,
    input  logic [PTR_W-1:0] rd_ptr,
    output logic [NBITS-1:0] rd_g01,
    output logic [NBITS-1:0] rd_g10
);

    logic [NBITS-1:0] mem_g01 [DEPTH];
    logic [NBITS-1:0] mem_g10 [DEPTH];
    logic             bypass;

    always_ff @(posedge CLK_) begin
        if (!reset_) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_g01[i] <= '0;
                mem_g10[i] <= '0;
            end
        end else if (we) begin
            mem_g01[wr_ptr] <= wr_g01;
            mem_g10[wr_ptr] <= wr_g10;
        end
    end

    // Reading the slot being written (lookahead of zero) returns the incoming
    // sample so the zero-lookahead case is a one-cycle pass-through.
    assign bypass = we && (rd_ptr == wr_ptr);
    assign rd_g01 = bypass ? wr_g01 : mem_g01[rd_ptr];
    assign rd_g10 = bypass ? wr_g10 : mem_g10[rd_ptr];

endmodule

// File: rtl/ldtu_gain_sel_fifo.sv
// ----------------------------------------------------------------------------
// ldtu_gain_sel_fifo
// Input FIFO and gain-selection stage. Both gains are buffered; each incoming
// gain x10 sample is the look-ahead reference that decides whether the sample
// L positions older is emitted from gain x1 (saturation hold window) or x10.
//
// Ports:
//   CLK_              in   clock
//   reset_            in   synchronous active-low reset
//   in_valid          in   sample strobe
//   DATA_gain_01      in   gain x1 sample
//   DATA_gain_10      in   gain x10 sample
//   GAIN_SEL_MODE     in   00 auto, 01 auto 2x window, 10 force x10, 11 force x1
//   window_len        in   hold window in samples (0 behaves as 1)
//   lookahead         in   reference distance L; a change flushes the stream
//   SATURATION_value  in   saturation threshold before shift
//   shift_gain_10     in   right shift applied to x10 data and threshold
//   clr_cnt           in   clears sat_count
//   DATA_to_enc       out  {gain bit (1 = x1), sample}
//   out_valid         out  DATA_to_enc valid
//   baseline_flag     out  emitted sample is baseline
//   gain_switch       out  pulse on gain change between consecutive outputs
//   sat_count         out  saturating count of saturated references
// ----------------------------------------------------------------------------
module ldtu_gain_sel_fifo
    import ldtu_pkg::*;
#(
    parameter int NBITS     = NBITS_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int PTR_W     = PTR_W_DEF,
    parameter int WIN_W     = WIN_W_DEF,
    parameter int BASE_BITS = BASE_BITS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             CLK_,
    input  logic             reset_,
    input  logic             in_valid,
    input  logic [NBITS-1:0] DATA_gain_01,
    input  logic [NBITS-1:0] DATA_gain_10,
    input  logic [1:0]       GAIN_SEL_MODE,
    input  logic [WIN_W-1:0] window_len,
    input  logic [PTR_W-1:0] lookahead,
    input  logic [NBITS-1:0] SATURATION_value,
    input  logic [1:0]       shift_gain_10,
    input  logic             clr_cnt,
    output logic [NBITS:0]   DATA_to_enc,
    output logic             out_valid,
    output logic             baseline_flag,
    output logic             gain_switch,
    output logic [CNT_W-1:0] sat_count
);

    localparam logic [PTR_W:0]   FILL_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [WIN_W:0]   WIN_ONE  = (WIN_W+1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    gain_mode_e       mode;
    logic             auto_mode;
    logic             flush;
    logic             accept;
    logic             rd_en;
    logic             ref_sat;
    logic             use_x1;
    logic             sat_event;
    logic             base_new;
    logic             have_prev;
    logic             last_gain;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] lookahead_q;
    logic [PTR_W:0]   fill;
    logic [PTR_W:0]   fill_full;
    logic [PTR_W:0]   fill_inc;
    logic [WIN_W:0]   hold_cnt;
    logic [WIN_W:0]   hold_next;
    logic [WIN_W:0]   win_raw;
    logic [WIN_W:0]   win_eff;
    logic [NBITS-1:0] sat_val;
    logic [NBITS-1:0] g10_shift;
    logic [NBITS-1:0] thr_shift;
    logic [NBITS-1:0] rd_g01;
    logic [NBITS-1:0] rd_g10;
    logic [NBITS:0]   out_word;

    ldtu_dual_ring #(
        .NBITS (NBITS),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ring (
        .CLK_   (CLK_),
        .reset_ (reset_),
        .we     (accept),
        .wr_ptr (wr_ptr),
        .wr_g01 (DATA_gain_01),
        .wr_g10 (g10_shift),
        .rd_ptr (rd_ptr),
        .rd_g01 (rd_g01),
        .rd_g10 (rd_g10)
    );

    // Stream control and gain decision.
    always_comb begin
        mode      = gain_mode_e'(GAIN_SEL_MODE);
        auto_mode = is_auto_mode(mode);
        // A lookahead change discards any sample offered in the same cycle;
        // the stream restarts from the next accepted sample.
        flush     = (lookahead != lookahead_q);
        accept    = in_valid && !flush;
        g10_shift = DATA_gain_10 >> shift_gain_10;
        thr_shift = SATURATION_value >> shift_gain_10;
        // fill_inc already includes the sample being written this cycle.
        fill_full = {1'b0, lookahead_q} + FILL_ONE;
        fill_inc  = (fill >= fill_full) ? fill_full : fill + FILL_ONE;
        rd_en     = accept && (fill_inc == fill_full);
        rd_ptr    = wr_ptr - lookahead_q;

        win_raw = (mode == MODE_AUTO2X) ? {window_len, 1'b0} : {1'b0, window_len};
        win_eff = (win_raw == '0) ? WIN_ONE : win_raw;

        ref_sat   = 1'b0;
        use_x1    = 1'b0;
        hold_next = hold_cnt;
        case (mode)
            MODE_AUTO, MODE_AUTO2X: begin
                ref_sat = (g10_shift >= sat_val);
                if (ref_sat) begin
                    hold_next = win_eff - WIN_ONE;
                    use_x1    = 1'b1;
                end else if (hold_cnt != '0) begin
                    hold_next = hold_cnt - WIN_ONE;
                    use_x1    = 1'b1;
                end
            end
            MODE_FORCE_G10: begin
                hold_next = '0;
            end
            default: begin
                ref_sat   = 1'b1;
                use_x1    = 1'b1;
                hold_next = '0;
            end
        endcase

        sat_event = accept && auto_mode && ref_sat;
    end

    // Output word formation, kept apart from the address logic feeding the ring.
    always_comb begin
        out_word = use_x1 ? {GAIN_X1, rd_g01} : {GAIN_X10, rd_g10};
        // Auto modes count the gain bit as part of the baseline test, so any
        // x1 sample there is never baseline.
        if (auto_mode) begin
            base_new = (out_word[NBITS:BASE_BITS] == '0);
        end else begin
            base_new = (out_word[NBITS-1:BASE_BITS] == '0);
        end
    end

    always_ff @(posedge CLK_) begin
        if (!reset_) begin
            wr_ptr        <= '0;
            fill          <= '0;
            hold_cnt      <= '0;
            sat_count     <= '0;
            sat_val       <= '1;
            lookahead_q   <= lookahead;
            DATA_to_enc   <= '0;
            out_valid     <= 1'b0;
            gain_switch   <= 1'b0;
            baseline_flag <= 1'b1;
            have_prev     <= 1'b0;
            last_gain     <= GAIN_X10;
        end else begin
            sat_val     <= thr_shift;
            lookahead_q <= lookahead;
            out_valid   <= rd_en;
            gain_switch <= rd_en && have_prev && (out_word[NBITS] != last_gain);

            if (flush) begin
                fill      <= '0;
                hold_cnt  <= '0;
                have_prev <= 1'b0;
            end else if (accept) begin
                wr_ptr   <= wr_ptr + PTR_ONE;
                fill     <= fill_inc;
                hold_cnt <= hold_next;
            end

            if (rd_en) begin
                DATA_to_enc   <= out_word;
                baseline_flag <= base_new;
                last_gain     <= out_word[NBITS];
                have_prev     <= 1'b1;
            end

            if (clr_cnt) begin
                sat_count <= sat_event ? CNT_ONE : '0;
            end else if (sat_event && (sat_count != '1)) begin
                sat_count <= sat_count + CNT_ONE;
            end
        end
    end

endmodule
